path_stack_sequencer: RTL and testbench
=======================================

# path_stack_sequencer

Sequencer for the maze solver's path stack. It owns the stack pointer and drives an external single-port synchronous stack RAM, serving push and pop requests from the solver FSM. Once the maze is solved, it replays the stored path from bottom to top toward the path display over a valid/ready handshake, then signals `finish`. It sits between the solver control unit, the stack RAM and the display/move unit.

## Interface
- `AW`, default 8: stack address width; depth is 2^AW entries.
- `DW`, default 2: direction code width (up, right, down, left).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `push` in 1: push request; `push_dir` is written.
- `push_dir` in DW: direction to store.
- `pop` in 1: pop request.
- `pop_valid` out 1: one-cycle pulse; `pop_dir` holds the popped entry.
- `pop_dir` out DW: popped direction, held until the next pop.
- `solved` in 1: start replay (level; sampled in RUN only).
- `busy` out 1: high whenever state is not RUN.
- `full` out 1, `empty` out 1: stack status.
- `depth` out AW+1: current entry count.
- `err` out 1: one-cycle pulse on a rejected request.
- `mem_we`, `mem_re` out 1; `mem_addr` out AW; `mem_wdata` out DW; `mem_rdata` in DW: RAM port (read data valid one cycle after `mem_re`).
- `move_valid` out 1, `move_dir` out DW, `move_ready` in 1: replay stream.
- `finish` out 1: one-cycle pulse at the end of replay.

## Operation
- **States:** RUN, POP_RD, POP_WAIT, REP_RD, REP_WAIT, REP_OUT, DONE.
- **Registered outputs:** all outputs are registered. Reset values: every output 0, except `empty`=1. `depth`=0, replay index=0, state=RUN.
- **RUN, `push` only:**
  - If not full: `mem_we`=1, `mem_addr`=depth, `mem_wdata`=`push_dir` for one cycle; depth+1. Stay in RUN.
  - If full: `err` pulses, no write.
- **RUN, `pop` only:**
  - If not empty: depth−1, go to POP_RD with `mem_re`=1 and `mem_addr`=new depth.
  - If empty: `err` pulses.
- **Pop path:** POP_RD → POP_WAIT (RAM latency). In POP_WAIT, capture `mem_rdata` into `pop_dir`, pulse `pop_valid`, return to RUN.
- **`push` and `pop` together in RUN:** both rejected, `err` pulses, stack unchanged.
- **`solved` priority:** `solved` in RUN has priority over `push`/`pop`; those are dropped silently.
  - depth=0: go to DONE.
  - Otherwise: index=0, go to REP_RD.
- **Replay loop:**
  - REP_RD: `mem_re`=1, `mem_addr`=index.
  - REP_WAIT: latency cycle.
  - REP_OUT: `move_valid`=1 and `move_dir`=captured data, held stable until `move_ready`.
  - On handshake: index+1. If index = depth−1, go to DONE; otherwise go to REP_RD.
- **Replay does not disturb the stack:** depth and contents are unchanged.
- **DONE:** `finish` pulses for one cycle, then return to RUN. A `solved` still high on return starts replay again; the solver must drop `solved` on `finish`.
- **Requests outside RUN:** `push`/`pop` while busy are rejected with an `err` pulse.
- **Invariants:** `full` = (depth == 2^AW); `empty` = (depth == 0). depth never wraps.
- **Reset mid-operation:** asynchronous clear to reset values. Any in-flight pop or replay is abandoned. RAM contents are irrelevant after reset.

## Timing
- **Push:** request sampled at edge N; `mem_we` high in cycle N+1; `depth` updates at N+1.
- **Pop:** request at edge N; `mem_re` in N+1; `pop_valid` in N+3. Next request is accepted at edge N+3.
- **Replay:** first `move_valid` appears 3 cycles after `solved` is sampled. With `move_ready` tied high, there is one move every 3 cycles.
- **`finish` latency:** one cycle after the last handshake; with empty stack, 1 cycle after `solved`.
- **Back-to-back pushes:** one per cycle.

## Structure
- Shared package `maze_pkg`:
  - Direction codes `DIR_UP`=0, `DIR_RIGHT`=1, `DIR_DOWN`=2, `DIR_LEFT`=3.
  - State enum type.
  - Default `AW`/`DW`.
- Single module with no sub-modules. The RAM is external; the existing stack memory module is instantiated beside this block by the top level.

## Test plan
- **Reset then push:** after reset, push dirs 1,2,3 on consecutive cycles → `mem_we` at addrs 0,1,2; depth=3; `empty`=0.
- **Pop:** from depth 3, pop → `mem_addr`=2; `pop_valid` 3 cycles later with `pop_dir`=3; depth=2.
- **Boundaries:** with AW=2, 4 pushes → `full`=1, and a 5th push gives `err` with depth=4. Pop on empty → `err`, depth stays 0. Push+pop same cycle → `err`, no change.
- **Replay:** stack 0,1,2,3 and `solved` with random `move_ready` stalls → `move_dir` sequence 0,1,2,3 with data held stable during stalls; `finish` one pulse; depth still 4.
- **Empty replay:** `solved` with depth=0 → `finish` after 1 cycle; no `move_valid`.
- **Reset mid-replay:** assert `rst` during REP_OUT → `move_valid`=0 immediately; depth=0; state RUN.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze solver definitions: direction codes, sequencer states, default widths.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package maze_pkg;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 2;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      POP_RD   = 3'd1,
      POP_WAIT = 3'd2,
      REP_RD   = 3'd3,
      REP_WAIT = 3'd4,
      REP_OUT  = 3'd5,
      DONE     = 3'd6
   } seq_state_t;

endpackage

// File: rtl/path_stack_sequencer_if.sv
// Bundle of all path stack sequencer signals: solver requests/status, stack RAM port, replay stream.
// Latency: n/a (wires only); RAM read data is expected one cycle after mem_re.
// Backpressure: replay stream is valid/ready; move_valid/move_dir held until move_ready.
// Modports: slave = the sequencer itself; master = its surroundings (solver, RAM, display).
interface path_stack_sequencer_if
   import maze_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) ();

   // solver side
   logic          push;
   logic [DW-1:0] push_dir;
   logic          pop;
   logic          pop_valid;
   logic [DW-1:0] pop_dir;
   logic          solved;
   logic          busy;
   logic          full;
   logic          empty;
   logic [AW:0]   depth;
   logic          err;
   // stack RAM side
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   // display side
   logic          move_valid;
   logic [DW-1:0] move_dir;
   logic          move_ready;
   logic          finish;

   modport slave (
      input  push, push_dir, pop, solved, mem_rdata, move_ready,
      output pop_valid, pop_dir, busy, full, empty, depth, err,
             mem_we, mem_re, mem_addr, mem_wdata, move_valid, move_dir, finish
   );

   modport master (
      output push, push_dir, pop, solved, mem_rdata, move_ready,
      input  pop_valid, pop_dir, busy, full, empty, depth, err,
             mem_we, mem_re, mem_addr, mem_wdata, move_valid, move_dir, finish
   );

endinterface

// File: rtl/path_stack_sequencer.sv
// Path stack sequencer: owns the stack pointer, serves push/pop on an external sync RAM, replays path bottom-up.
// Latency: push 1 cycle; pop result 3 cycles after request; replay 3 cycles per move, finish 1 cycle after last move.
// Backpressure: move_valid/move_dir held until move_ready; push/pop while busy are rejected with an err pulse.
// Ports: clk, rst (async, active high), bus (slave modport: requests, status, RAM port, replay stream).
module path_stack_sequencer
   import maze_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic                  clk,
   input  logic                  rst,
   path_stack_sequencer_if.slave bus
);

   localparam logic [AW:0]   DEPTH_MAX = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   D_ONE     = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] I_ONE     = {{(AW-1){1'b0}}, 1'b1};

   seq_state_t    state_q, state_n;

   logic [AW:0]   depth_q, depth_n;
   logic [AW-1:0] idx_q, idx_n;
   logic          mem_we_q, mem_we_n;
   logic          mem_re_q, mem_re_n;
   logic [AW-1:0] mem_addr_q, mem_addr_n;
   logic [DW-1:0] mem_wdata_q, mem_wdata_n;
   logic          err_q, err_n;
   logic          pop_valid_q, pop_valid_n;
   logic [DW-1:0] pop_dir_q, pop_dir_n;
   logic          move_valid_q, move_valid_n;
   logic [DW-1:0] move_dir_q, move_dir_n;
   logic          finish_q, finish_n;
   logic          busy_q, busy_n;
   logic          full_q, full_n;
   logic          empty_q, empty_n;

   logic          last_idx;

   // replay index points at the topmost entry
   assign last_idx = (({1'b0, idx_q} + D_ONE) == depth_q);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_n;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_n = state_q;
      case (state_q)
         RUN: begin
            // solved wins over push/pop
            if (bus.solved) begin
               state_n = empty_q ? DONE : REP_RD;
            end else if (bus.pop && !bus.push && !empty_q) begin
               state_n = POP_RD;
            end
         end
         POP_RD:   state_n = POP_WAIT;
         POP_WAIT: state_n = RUN;
         REP_RD:   state_n = REP_WAIT;
         REP_WAIT: state_n = REP_OUT;
         REP_OUT: begin
            if (bus.move_ready) begin
               state_n = last_idx ? DONE : REP_RD;
            end
         end
         DONE:     state_n = RUN;
         default:  state_n = RUN;
      endcase
   end

   // ---------------- output logic (next values of the registered outputs) ----------------
   always_comb begin
      depth_n      = depth_q;
      idx_n        = idx_q;
      mem_we_n     = 1'b0;
      mem_re_n     = 1'b0;
      mem_addr_n   = mem_addr_q;
      mem_wdata_n  = mem_wdata_q;
      err_n        = 1'b0;
      pop_valid_n  = 1'b0;
      pop_dir_n    = pop_dir_q;
      move_valid_n = move_valid_q;
      move_dir_n   = move_dir_q;
      finish_n     = 1'b0;

      if (state_q != RUN) begin
         err_n = bus.push || bus.pop;
      end

      case (state_q)
         RUN: begin
            if (bus.solved) begin
               idx_n = '0;
               if (empty_q) begin
                  finish_n = 1'b1;
               end else begin
                  mem_re_n   = 1'b1;
                  mem_addr_n = '0;
               end
            end else if (bus.push && bus.pop) begin
               err_n = 1'b1;
            end else if (bus.push) begin
               if (full_q) begin
                  err_n = 1'b1;
               end else begin
                  mem_we_n    = 1'b1;
                  mem_addr_n  = depth_q[AW-1:0];
                  mem_wdata_n = bus.push_dir;
                  depth_n     = depth_q + D_ONE;
               end
            end else if (bus.pop) begin
               if (empty_q) begin
                  err_n = 1'b1;
               end else begin
                  // low AW bits of depth-1 are the top entry, also when full
                  mem_re_n   = 1'b1;
                  mem_addr_n = depth_q[AW-1:0] - I_ONE;
                  depth_n    = depth_q - D_ONE;
               end
            end
         end
         POP_WAIT: begin
            pop_dir_n   = bus.mem_rdata;
            pop_valid_n = 1'b1;
         end
         REP_WAIT: begin
            move_dir_n   = bus.mem_rdata;
            move_valid_n = 1'b1;
         end
         REP_OUT: begin
            if (bus.move_ready) begin
               move_valid_n = 1'b0;
               if (last_idx) begin
                  finish_n = 1'b1;
               end else begin
                  idx_n      = idx_q + I_ONE;
                  mem_re_n   = 1'b1;
                  mem_addr_n = idx_q + I_ONE;
               end
            end
         end
         default: ;
      endcase

      busy_n  = (state_n != RUN);
      full_n  = (depth_n == DEPTH_MAX);
      empty_n = (depth_n == '0);
   end

   // ---------------- output registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth_q      <= '0;
         idx_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         err_q        <= 1'b0;
         pop_valid_q  <= 1'b0;
         pop_dir_q    <= '0;
         move_valid_q <= 1'b0;
         move_dir_q   <= '0;
         finish_q     <= 1'b0;
         busy_q       <= 1'b0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
      end else begin
         depth_q      <= depth_n;
         idx_q        <= idx_n;
         mem_we_q     <= mem_we_n;
         mem_re_q     <= mem_re_n;
         mem_addr_q   <= mem_addr_n;
         mem_wdata_q  <= mem_wdata_n;
         err_q        <= err_n;
         pop_valid_q  <= pop_valid_n;
         pop_dir_q    <= pop_dir_n;
         move_valid_q <= move_valid_n;
         move_dir_q   <= move_dir_n;
         finish_q     <= finish_n;
         busy_q       <= busy_n;
         full_q       <= full_n;
         empty_q      <= empty_n;
      end
   end

   assign bus.depth      = depth_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_re     = mem_re_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.err        = err_q;
   assign bus.pop_valid  = pop_valid_q;
   assign bus.pop_dir    = pop_dir_q;
   assign bus.move_valid = move_valid_q;
   assign bus.move_dir   = move_dir_q;
   assign bus.finish     = finish_q;
   assign bus.busy       = busy_q;
   assign bus.full       = full_q;
   assign bus.empty      = empty_q;

endmodule

// File: tb/tb_path_stack_sequencer.sv
// Bench for path_stack_sequencer: vector table, hand sequences, randomized ops against a stack model.
// Latency: n/a.
// Backpressure: drives random move_ready stalls on the replay stream.
module tb_path_stack_sequencer;
   import maze_pkg::*;

   localparam int AW   = 2;
   localparam int DW   = 2;
   localparam int NENT = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   path_stack_sequencer_if #(.AW(AW), .DW(DW)) bus ();

   path_stack_sequencer #(.AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // external single-port synchronous stack RAM
   logic [DW-1:0] ram [NENT];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
   end

   int total = 0;
   int bad   = 0;

   // reference: the stack contents, bottom at index 0
   logic [DW-1:0] stk [$];

   typedef struct {
      logic          push;
      logic [DW-1:0] dir;
      logic          pop;
      logic          e_we;
      int            e_addr;
      int            e_depth;
      logic          e_err;
      logic          e_full;
      logic          e_empty;
   } vec_t;

   vec_t vt [11];

   function automatic vec_t mk(input logic p, input logic [DW-1:0] d, input logic q,
                               input logic we, input int addr, input int dep,
                               input logic er, input logic fu, input logic em);
      vec_t v;
      v.push = p; v.dir = d; v.pop = q;
      v.e_we = we; v.e_addr = addr; v.e_depth = dep;
      v.e_err = er; v.e_full = fu; v.e_empty = em;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.push     = vt[i].push;
         bus.push_dir = vt[i].dir;
         bus.pop      = vt[i].pop;
         @(negedge clk);
         bus.push = 1'b0;
         bus.pop  = 1'b0;
         chk($sformatf("vec%0d_we", i), bus.mem_we, vt[i].e_we);
         if (vt[i].e_we) begin
            chk($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vt[i].dir);
            stk.push_back(vt[i].dir);
         end
         chk($sformatf("vec%0d_re", i), bus.mem_re, 0);
         chk($sformatf("vec%0d_depth", i), bus.depth, vt[i].e_depth);
         chk($sformatf("vec%0d_err", i), bus.err, vt[i].e_err);
         chk($sformatf("vec%0d_full", i), bus.full, vt[i].e_full);
         chk($sformatf("vec%0d_empty", i), bus.empty, vt[i].e_empty);
         chk($sformatf("vec%0d_pop_valid", i), bus.pop_valid, 0);
      end
   endtask

   // one request from RUN, checked against the stack model
   task automatic do_op(input bit p, input bit q, input logic [DW-1:0] d);
      bit            exp_err;
      logic [DW-1:0] exp_dir;
      int            n;
      exp_err = (p && q) || (p && !q && stk.size() == NENT) || (q && !p && stk.size() == 0);
      bus.push     = p;
      bus.pop      = q;
      bus.push_dir = d;
      @(negedge clk);
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      chk("op_err", bus.err, exp_err);
      if (p && !q && !exp_err) begin
         chk("op_push_we", bus.mem_we, 1);
         chk("op_push_addr", bus.mem_addr, stk.size());
         chk("op_push_wdata", bus.mem_wdata, d);
         stk.push_back(d);
      end else begin
         chk("op_no_we", bus.mem_we, 0);
      end
      if (q && !p && !exp_err) begin
         exp_dir = stk.pop_back();
         chk("op_pop_re", bus.mem_re, 1);
         chk("op_pop_addr", bus.mem_addr, stk.size());
         n = 0;
         while (!bus.pop_valid && n < 8) begin
            @(negedge clk);
            n++;
         end
         chk("op_pop_latency", n, 2);
         chk("op_pop_dir", bus.pop_dir, exp_dir);
         chk("op_pop_busy", bus.busy, 0);
      end
      chk("op_depth", bus.depth, stk.size());
      chk("op_full", bus.full, (stk.size() == NENT) ? 1 : 0);
      chk("op_empty", bus.empty, (stk.size() == 0) ? 1 : 0);
   endtask

   // replay with random stalls; checks order, stability, timing, single finish
   task automatic do_replay(input int stall_pct, input bit poke_busy);
      logic [DW-1:0] got [$];
      logic [DW-1:0] held;
      int  n_fin   = 0;
      int  fin_cyc = -1;
      int  first_v = -1;
      int  last_hs = -1;
      bit  pend    = 1'b0;
      int  dep0;
      dep0 = stk.size();
      held = '0;
      bus.solved = 1'b1;
      @(negedge clk);
      bus.solved = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (poke_busy && cyc == 2) begin
            bus.push = 1'b0;
            chk("busy_push_err", bus.err, 1);
            chk("busy_push_no_we", bus.mem_we, 0);
         end
         if (poke_busy && cyc == 1) bus.push = 1'b1;
         if (bus.finish) begin
            n_fin++;
            if (fin_cyc < 0) fin_cyc = cyc;
         end
         if (bus.move_valid) begin
            if (first_v < 0) first_v = cyc;
            if (pend) chk("rep_hold_dir", bus.move_dir, held);
            bus.move_ready = ($urandom_range(0, 99) >= stall_pct);
            if (bus.move_ready) begin
               got.push_back(bus.move_dir);
               pend    = 1'b0;
               last_hs = cyc;
            end else begin
               pend = 1'b1;
               held = bus.move_dir;
            end
         end else begin
            if (pend) begin
               chk("rep_valid_held", bus.move_valid, 1);
               pend = 1'b0;
            end
            bus.move_ready = 1'($urandom_range(0, 1));
         end
         if (fin_cyc > 0 && cyc >= fin_cyc + 3) break;
         @(negedge clk);
      end
      bus.move_ready = 1'b0;
      chk("rep_finish_count", n_fin, 1);
      chk("rep_move_count", got.size(), dep0);
      for (int i = 0; i < got.size() && i < dep0; i++) begin
         chk($sformatf("rep_dir%0d", i), got[i], stk[i]);
      end
      if (dep0 > 0) begin
         chk("rep_first_latency", first_v, 3);
         chk("rep_finish_latency", fin_cyc, last_hs + 1);
      end else begin
         chk("rep_empty_finish_latency", fin_cyc, 1);
         chk("rep_empty_no_move", first_v, -1);
      end
      chk("rep_depth_kept", bus.depth, dep0);
      chk("rep_busy_after", bus.busy, 0);
   endtask

   initial begin
      bus.push       = 1'b0;
      bus.pop        = 1'b0;
      bus.push_dir   = '0;
      bus.solved     = 1'b0;
      bus.move_ready = 1'b0;

      vt[0]  = mk(1, 2'd1, 0, 1, 0, 1, 0, 0, 0);
      vt[1]  = mk(1, 2'd2, 0, 1, 1, 2, 0, 0, 0);
      vt[2]  = mk(1, 2'd3, 0, 1, 2, 3, 0, 0, 0);
      vt[3]  = mk(1, 2'd3, 0, 1, 2, 3, 0, 0, 0);
      vt[4]  = mk(1, 2'd0, 0, 1, 3, 4, 0, 1, 0);
      vt[5]  = mk(1, 2'd2, 0, 0, 0, 4, 1, 1, 0);
      vt[6]  = mk(1, 2'd1, 1, 0, 0, 4, 1, 1, 0);
      vt[7]  = mk(0, 2'd0, 0, 0, 0, 4, 0, 1, 0);
      vt[8]  = mk(0, 2'd0, 1, 0, 0, 0, 1, 0, 1);
      vt[9]  = mk(1, 2'd2, 1, 0, 0, 0, 1, 0, 1);
      vt[10] = mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 1);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_depth", bus.depth, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_re", bus.mem_re, 0);
      chk("rst_move_valid", bus.move_valid, 0);
      chk("rst_finish", bus.finish, 0);
      chk("rst_pop_valid", bus.pop_valid, 0);

      // pushes 1,2,3 back to back
      apply_range(0, 2);

      // pop from depth 3
      bus.pop = 1'b1;
      @(negedge clk);
      bus.pop = 1'b0;
      chk("pop_re", bus.mem_re, 1);
      chk("pop_addr", bus.mem_addr, 2);
      chk("pop_depth", bus.depth, 2);
      chk("pop_busy", bus.busy, 1);
      @(negedge clk);
      chk("pop_valid_early", bus.pop_valid, 0);
      @(negedge clk);
      chk("pop_valid", bus.pop_valid, 1);
      chk("pop_dir", bus.pop_dir, 3);
      chk("pop_busy_done", bus.busy, 0);
      void'(stk.pop_back());

      // next request accepted right away, then fill, overflow, push+pop
      apply_range(3, 7);

      // drain and underflow
      for (int i = 0; i < NENT; i++) do_op(1'b0, 1'b1, '0);
      apply_range(8, 10);

      // replay of an empty stack
      do_replay(0, 1'b1);

      // stack 0,1,2,3 replayed with stalls
      for (int i = 0; i < NENT; i++) do_op(1'b1, 1'b0, DW'(i));
      do_replay(40, 1'b1);
      chk("rep_full_kept", bus.full, 1);

      // randomized traffic with periodic replays
      for (int i = 0; i < 80; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 4)       do_op(1'b1, 1'b0, DW'($urandom_range(0, 3)));
         else if (r < 7)  do_op(1'b0, 1'b1, '0);
         else if (r == 7) do_op(1'b1, 1'b1, DW'($urandom_range(0, 3)));
         else             do_op(1'b0, 1'b0, '0);
         if (i % 20 == 19) do_replay($urandom_range(0, 70), 1'b0);
      end

      // reset while a move is presented
      while (stk.size() < 3) do_op(1'b1, 1'b0, DW'($urandom_range(0, 3)));
      bus.move_ready = 1'b0;
      bus.solved = 1'b1;
      @(negedge clk);
      bus.solved = 1'b0;
      for (int n = 0; n < 10 && !bus.move_valid; n++) @(negedge clk);
      chk("mid_in_rep_out", bus.move_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_move_valid", bus.move_valid, 0);
      chk("mid_depth", bus.depth, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_empty", bus.empty, 1);
      stk.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", bus.busy, 0);
      do_op(1'b1, 1'b0, 2'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
